// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encoding, default sizes and length clamp for seq_tx
package seq_tx_pkg;

  localparam int W_DEF         = 12;
  localparam int PULSE_CYC_DEF = 3;
  localparam int GAP_CYC_DEF   = 125;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    logic [3:0] w_max;
    w_max = max_len[3:0];
    return (int'(len) > max_len) ? w_max : len;
  endfunction

endpackage

// File: rtl/seq_tx_if.sv
// rtl/seq_tx_if.sv - request/serial-output bundle between a burst requester and seq_tx
interface seq_tx_if #(parameter int W = 12);

  logic         start;
  logic [W-1:0] pattern;
  logic [3:0]   len;
  logic         ser_in;
  logic         next;
  logic         busy;
  logic         done;
  logic [2:0]   state_display;
  logic [3:0]   bit_idx;

  modport master (
    output start, pattern, len,
    input  ser_in, next, busy, done, state_display, bit_idx
  );

  modport slave (
    input  start, pattern, len,
    output ser_in, next, busy, done, state_display, bit_idx
  );

endinterface

// File: rtl/seq_tx_timer.sv
// rtl/seq_tx_timer.sv - loadable down-counter timing the PULSE and GAP phases
module seq_tx_timer #(
  parameter int TW = 7
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic          o_zero
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial pattern transmitter with setup/pulse/gap strobing per bit
// SEQ_TX_LOOP_EN: restart the latched pattern at the last gap exit while start is held.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic   i_clk,
  input  logic   i_reset,
  seq_tx_if.slave bus
);

  localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);

  state_t       r_state;
  logic [W-1:0] r_shift;
  logic [3:0]   r_len;
  logic [3:0]   r_bit_idx;
  logic         r_in;
  logic         r_next;
  logic         r_busy;
  logic         r_done;
`ifdef SEQ_TX_LOOP_EN
  logic [W-1:0] r_pat;
`endif

  logic          w_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic [3:0]    w_len_clamped;
  logic [4:0]    w_idx_inc;
  logic          w_last;
  logic [W-1:0]  w_shift_nxt;

  // Timer is armed for PULSE while in SETUP and re-armed for GAP as PULSE expires.
  assign w_load        = (r_state == S_SETUP) || ((r_state == S_PULSE) && w_zero);
  assign w_load_val    = (r_state == S_SETUP) ? PULSE_LD : GAP_LD;
  assign w_len_clamped = clamp_len(bus.len, W);
  assign w_idx_inc     = {1'b0, r_bit_idx} + 5'd1;
  assign w_last        = !(w_idx_inc < {1'b0, r_len});
  assign w_shift_nxt   = {r_shift[W-2:0], 1'b0};

  seq_tx_timer #(.TW(TW)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_len     <= '0;
      r_bit_idx <= '0;
      r_in      <= 1'b0;
      r_next    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_TX_LOOP_EN
      r_pat     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in   <= 1'b0;
          r_next <= 1'b0;
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_shift   <= bus.pattern;
`ifdef SEQ_TX_LOOP_EN
            r_pat     <= bus.pattern;
`endif
            r_len     <= w_len_clamped;
            r_bit_idx <= '0;
            r_busy    <= 1'b1;
            if (w_len_clamped == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SETUP;
              r_in    <= bus.pattern[W-1];
            end
          end
        end
        S_SETUP: begin
          r_state <= S_PULSE;
          r_next  <= 1'b1;
        end
        S_PULSE: begin
          if (w_zero) begin
            r_state <= S_GAP;
            r_next  <= 1'b0;
          end
        end
        S_GAP: begin
          if (w_zero) begin
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_idx_inc[3:0];
            if (!w_last) begin
              r_state <= S_SETUP;
              r_in    <= w_shift_nxt[W-1];
            end
`ifdef SEQ_TX_LOOP_EN
            else if (bus.start) begin
              r_shift   <= r_pat;
              r_bit_idx <= '0;
              r_state   <= S_SETUP;
              r_in      <= r_pat[W-1];
            end
`endif
            else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_in    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ser_in        = r_in;
  assign bus.next          = r_next;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.state_display = r_state;
  assign bus.bit_idx       = r_bit_idx;

endmodule
